// File: rtl/mc_cpu_core_if.sv
// rtl/mc_cpu_core_if.sv - valid/ready memory bus between mc_cpu_core and system memory
interface mc_cpu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_cpu_core.sv
// rtl/mc_cpu_core.sv - multi-cycle register-file CPU core; MC_CPU_MUL_EN enables opcode C = MUL
module mc_cpu_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mc_cpu_core_if.master bus,
    output logic          halt,
    output logic          illegal
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4, OP_NOT = 4'h5, OP_LDI = 4'h6, OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC, OP_HLT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, d_q, d_d, res_q, res_d;
    logic              cres_q, cres_d, z_q, z_d, c_q, c_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              halt_q, halt_d, illegal_q, illegal_d;
    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] ea;
    logic [3:0]        op;
`ifdef MC_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    // Reserved opcodes and any register field the opcode actually uses that is out of range
    function automatic logic is_illegal(input logic [15:0] ins);
        logic bad_rd, bad_rs, bad_rt;
        bad_rd = int'(ins[11:8]) >= NREGS;
        bad_rs = int'(ins[7:4])  >= NREGS;
        bad_rt = int'(ins[3:0])  >= NREGS;
        case (ins[15:12])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_illegal = bad_rd | bad_rs | bad_rt;
            OP_NOT, OP_LD, OP_ST:                  is_illegal = bad_rd | bad_rs;
            OP_LDI:                                is_illegal = bad_rd;
            OP_JMP, OP_JZ, OP_JC:                  is_illegal = bad_rs;
`ifdef MC_CPU_MUL_EN
            OP_MUL:                                is_illegal = bad_rd | bad_rs | bad_rt;
`endif
            OP_HLT:                                is_illegal = 1'b0;
            default:                               is_illegal = 1'b1;
        endcase
    endfunction

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign halt          = halt_q;
    assign illegal       = illegal_q;

    // Next-state, datapath and registered-output computation for every FSM state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        res_d       = res_q;
        cres_d      = cres_q;
        z_d         = z_q;
        c_d         = c_q;
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        illegal_d   = 1'b0;
        op          = ir_q[15:12];
        sum         = '0;
        ea          = a_q[ADDR_W-1:0] + ADDR_W'(ir_q[3:0]);
`ifdef MC_CPU_MUL_EN
        prod        = '0;
`endif
        case (state_q)
            S_FETCH: begin
                // The first cycle after reset has no request yet; raise it here
                if (mem_req_q && bus.mem_ready) begin
                    ir_d      = bus.mem_rdata[15:0];
                    pc_d      = pc_q + ADDR_W'(1);
                    illegal_d = is_illegal(bus.mem_rdata[15:0]);
                    state_d   = S_DECODE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            S_DECODE: begin
                for (int i = 0; i < NREGS; i++) begin
                    if (ir_q[7:4]  == i[3:0]) a_d = regs_q[i];
                    if (ir_q[3:0]  == i[3:0]) b_d = regs_q[i];
                    if (ir_q[11:8] == i[3:0]) d_d = regs_q[i];
                end
                if (op == OP_HLT)           state_d = S_HALTED;
                else if (is_illegal(ir_q))  state_d = S_FETCH;
                else                        state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
                cres_d  = 1'b0;
                case (op)
                    OP_ADD: begin
                        sum    = {1'b0, a_q} + {1'b0, b_q};
                        res_d  = sum[DATA_W-1:0];
                        cres_d = sum[DATA_W];
                    end
                    OP_SUB: begin
                        res_d  = a_q - b_q;
                        cres_d = (a_q >= b_q);
                    end
                    OP_AND: res_d = a_q & b_q;
                    OP_OR:  res_d = a_q | b_q;
                    OP_XOR: res_d = a_q ^ b_q;
                    OP_NOT: res_d = ~a_q;
                    OP_LDI: res_d = DATA_W'(ir_q[7:0]);
`ifdef MC_CPU_MUL_EN
                    OP_MUL: begin
                        prod   = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
                        res_d  = prod[DATA_W-1:0];
                        cres_d = |prod[2*DATA_W-1:DATA_W];
                    end
`endif
                    OP_LD, OP_ST: begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op == OP_ST);
                        mem_addr_d  = ea;
                        mem_wdata_d = d_q;
                    end
                    OP_JMP: begin
                        pc_d    = ea;
                        state_d = S_FETCH;
                    end
                    OP_JZ: begin
                        if (z_q) pc_d = ea;
                        state_d = S_FETCH;
                    end
                    OP_JC: begin
                        if (c_q) pc_d = ea;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Address, direction and write data stay put until the memory accepts
                if (mem_req_q && bus.mem_ready) begin
                    if (op == OP_LD) begin
                        res_d   = bus.mem_rdata;
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            S_WRITEBACK: begin
                for (int i = 0; i < NREGS; i++)
                    if (ir_q[11:8] == i[3:0]) regs_d[i] = res_q;
                if (op <= OP_LD || op == OP_MUL) z_d = (res_q == '0);
                if (op <= OP_NOT || op == OP_MUL) c_d = cres_q;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
        // Every entry into FETCH issues the instruction request in its first cycle
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_d;
        end
        halt_d = (state_d == S_HALTED);
    end

    // State and registered outputs; synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            res_q       <= '0;
            cres_q      <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halt_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            res_q       <= res_d;
            cres_q      <= cres_d;
            z_q         <= z_d;
            c_q         <= c_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halt_q      <= halt_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_mc_cpu_core.sv
// tb/tb_mc_cpu_core.sv - directed self-checking bench for mc_cpu_core
module tb_mc_cpu_core;
    logic clk = 1'b0;
    logic reset;
    logic halt, illegal;

    mc_cpu_core_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mc_cpu_core #(.DATA_W(16), .ADDR_W(16), .NREGS(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .halt    (halt),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    int checks = 0;
    int fails  = 0;
    int cyc = 0, wait_n = 0, wcnt = 0;
    int fetch_cyc [int];
    int fetch_log [$];
    int halt_cyc = -1;
    int ill_cycles = 0, ill_rises = 0;
    logic ill_prev = 1'b0;
    int rd12 = 0;
    int last_wr_addr = -1;
    logic [15:0] last_wr_data = '0;

    // One cycle: memory model and monitors run at the negedge, away from the active edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.mem_ready = bus.mem_req && (wcnt >= wait_n);
        bus.mem_rdata = mem[bus.mem_addr];
        if (bus.mem_req && bus.mem_ready && !reset) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] = bus.mem_wdata;
                last_wr_addr = int'(bus.mem_addr);
                last_wr_data = bus.mem_wdata;
            end else begin
                fetch_log.push_back(int'(bus.mem_addr));
                fetch_cyc[int'(bus.mem_addr)] = cyc;
            end
            wcnt = 0;
        end else if (bus.mem_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
        if (illegal) begin
            ill_cycles++;
            if (!ill_prev) ill_rises++;
        end
        ill_prev = illegal;
        if (halt && halt_cyc < 0) halt_cyc = cyc;
        if (bus.mem_req && !bus.mem_we && bus.mem_addr == 16'h0012) rd12++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wait_n = 0;
        repeat (3) tick();
        reset = 1'b0;
        fetch_log.delete();
        fetch_cyc.delete();
        halt_cyc = -1;
        last_wr_addr = -1;
    endtask

    task automatic run_until_halt(input string name, input int max);
        int n = 0;
        while (!halt && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (halt !== 1'b1) begin
            fails++;
            $display("FAIL %s_halt: halt=%b after %0d cycles, required 1", name, halt, n);
        end
    endtask

    function automatic int last_fetch();
        if (fetch_log.size() == 0) return -1;
        return fetch_log[fetch_log.size()-1];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (bus.mem_req !== 1'b0)       begin fails++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
        if (bus.mem_we !== 1'b0)        begin fails++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
        if (bus.mem_addr !== 16'h0)     begin fails++; $display("FAIL rst_addr: got %h want 0000", bus.mem_addr); end
        if (bus.mem_wdata !== 16'h0)    begin fails++; $display("FAIL rst_wdata: got %h want 0000", bus.mem_wdata); end
        if (halt !== 1'b0)              begin fails++; $display("FAIL rst_halt: got %b want 0", halt); end
        if (illegal !== 1'b0)           begin fails++; $display("FAIL rst_illegal: got %b want 0", illegal); end
    endtask

    task automatic test_alu_add();
        clear_mem();
        mem[0] = 16'h6105; mem[1] = 16'h62FB; mem[2] = 16'h0312; mem[3] = 16'hA00C;
        mem[4] = 16'hB00C; mem[5] = 16'h830F; mem[6] = 16'hF000; mem[12] = 16'hF000;
        do_reset();
        run_until_halt("add", 200);
        checks += 8;
        if (mem[15] !== 16'h0100) begin fails++; $display("FAIL add_result: got %h want 0100", mem[15]); end
        if (fetch_cyc[1] - fetch_cyc[0] != 4) begin fails++; $display("FAIL ldi_cycles: got %0d want 4", fetch_cyc[1] - fetch_cyc[0]); end
        if (fetch_cyc[3] - fetch_cyc[2] != 4) begin fails++; $display("FAIL add_cycles: got %0d want 4", fetch_cyc[3] - fetch_cyc[2]); end
        if (fetch_cyc[4] - fetch_cyc[3] != 3) begin fails++; $display("FAIL jz_nt_cycles: got %0d want 3", fetch_cyc[4] - fetch_cyc[3]); end
        if (fetch_cyc[5] - fetch_cyc[4] != 3) begin fails++; $display("FAIL jc_nt_cycles: got %0d want 3", fetch_cyc[5] - fetch_cyc[4]); end
        if (fetch_cyc[6] - fetch_cyc[5] != 4) begin fails++; $display("FAIL store_cycles: got %0d want 4", fetch_cyc[6] - fetch_cyc[5]); end
        if (halt_cyc - fetch_cyc[6] != 2) begin fails++; $display("FAIL halt_latency: got %0d want 2", halt_cyc - fetch_cyc[6]); end
        if (last_fetch() != 6) begin fails++; $display("FAIL add_flags_path: last fetch %0h want 6", last_fetch()); end
    endtask

    task automatic test_not_sub();
        clear_mem();
        mem[0] = 16'h61FF; mem[1] = 16'h5110; mem[2] = 16'h6201; mem[3] = 16'h1021;
        mem[4] = 16'h6320; mem[5] = 16'h8130; mem[6] = 16'h8031; mem[7] = 16'hB038;
        mem[8] = 16'hF000; mem[16'h28] = 16'hF000;
        do_reset();
        run_until_halt("notsub", 300);
        checks += 3;
        if (mem[16'h20] !== 16'hFF00) begin fails++; $display("FAIL not_result: got %h want ff00", mem[16'h20]); end
        if (mem[16'h21] !== 16'h0101) begin fails++; $display("FAIL sub_result: got %h want 0101", mem[16'h21]); end
        if (last_fetch() != 8) begin fails++; $display("FAIL sub_carry: last fetch %0h want 8", last_fetch()); end
    endtask

    task automatic test_load_wait();
        clear_mem();
        mem[0] = 16'h6110; mem[1] = 16'h7012; mem[2] = 16'h8013; mem[3] = 16'hF000;
        mem[16'h12] = 16'hBEEF;
        do_reset();
        wait_n = 3;
        rd12 = 0;
        run_until_halt("load", 300);
        checks += 4;
        if (mem[16'h13] !== 16'hBEEF) begin fails++; $display("FAIL load_data: got %h want beef", mem[16'h13]); end
        if (rd12 != 4) begin fails++; $display("FAIL load_req_stable: got %0d cycles at 0x12 want 4", rd12); end
        if (fetch_cyc[2] - fetch_cyc[1] != 11) begin fails++; $display("FAIL load_wait_cycles: got %0d want 11", fetch_cyc[2] - fetch_cyc[1]); end
        if (last_fetch() != 3) begin fails++; $display("FAIL load_path: last fetch %0h want 3", last_fetch()); end
        wait_n = 0;
    endtask

    task automatic test_store_wrap();
        int wrapped = 0;
        clear_mem();
        mem[0] = 16'hA008; mem[1] = 16'h5100; mem[2] = 16'h8010; mem[3] = 16'h9010;
        mem[8] = 16'hF000; mem[16'hFFFF] = 16'hF000;
        do_reset();
        run_until_halt("wrap", 300);
        for (int i = 1; i < fetch_log.size(); i++)
            if (fetch_log[i-1] == 16'hFFFF && fetch_log[i] == 0) wrapped = 1;
        checks += 4;
        if (last_wr_addr != 16'hFFFF) begin fails++; $display("FAIL store_addr: got %0h want ffff", last_wr_addr); end
        if (mem[16'hFFFF] !== 16'h0000) begin fails++; $display("FAIL store_data: got %h want 0000", mem[16'hFFFF]); end
        if (wrapped != 1) begin fails++; $display("FAIL pc_wrap: got %0d want 1", wrapped); end
        if (last_fetch() != 8) begin fails++; $display("FAIL wrap_path: last fetch %0h want 8", last_fetch()); end
    endtask

    task automatic test_jumps();
        int exp_order [7] = '{0, 1, 2, 3, 16'h43, 16'h44, 16'h45};
        clear_mem();
        mem[0] = 16'h6240; mem[1] = 16'h6107; mem[2] = 16'h1011; mem[3] = 16'hA023;
        mem[16'h43] = 16'h0111; mem[16'h44] = 16'hB02A; mem[16'h45] = 16'hF000; mem[16'h4A] = 16'hF000;
        do_reset();
        run_until_halt("jump", 300);
        checks++;
        if (fetch_log.size() != 7) begin
            fails++;
            $display("FAIL jump_fetch_count: got %0d want 7", fetch_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (fetch_log[i] != exp_order[i]) begin
                    fails++;
                    $display("FAIL jump_order[%0d]: got %0h want %0h", i, fetch_log[i], exp_order[i]);
                end
            end
        end
        checks++;
        if (fetch_cyc[16'h43] - fetch_cyc[3] != 3) begin fails++; $display("FAIL jz_taken_cycles: got %0d want 3", fetch_cyc[16'h43] - fetch_cyc[3]); end
    endtask

    task automatic test_illegal_reset_halt();
        int base_c, base_r, n, good;
        clear_mem();
        mem[0] = 16'hD000; mem[1] = 16'h0040; mem[2] = 16'hF000;
        do_reset();
        base_c = ill_cycles;
        base_r = ill_rises;
        n = 0;
        while (ill_rises - base_r < 2 && n < 100) begin tick(); n++; end
        checks += 2;
        if (ill_rises - base_r != 2) begin fails++; $display("FAIL illegal_pulses: got %0d want 2", ill_rises - base_r); end
        if (ill_cycles - base_c != 2) begin fails++; $display("FAIL illegal_width: got %0d cycles want 2", ill_cycles - base_c); end
        wait_n = 5;
        n = 0;
        while (!bus.mem_req && n < 10) begin tick(); n++; end
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0002) begin
            fails++;
            $display("FAIL fetch_wait_req: req=%b addr=%h want 1/0002", bus.mem_req, bus.mem_addr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_drop_req: got %b want 0", bus.mem_req); end
        mem[0] = 16'hF000;
        tick();
        reset  = 1'b0;
        wait_n = 0;
        halt_cyc = -1;
        base_r = ill_rises;
        run_until_halt("halt", 50);
        good = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (halt === 1'b1 && bus.mem_req === 1'b0) good++;
        end
        checks += 2;
        if (good != 10) begin fails++; $display("FAIL halt_sticky: got %0d quiet halted cycles want 10", good); end
        if (ill_rises != base_r) begin fails++; $display("FAIL halt_no_illegal: got %0d pulses want 0", ill_rises - base_r); end
        reset = 1'b1;
        tick();
        checks++;
        if (halt !== 1'b0) begin fails++; $display("FAIL halt_cleared: got %b want 0", halt); end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        clear_mem();
        test_reset();
        test_alu_add();
        test_not_sub();
        test_load_wait();
        test_store_wrap();
        test_jumps();
        test_illegal_reset_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
